// File: rtl/psm_deadtime_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psm_pkg
//  Description : Shared encodings for the PSM dead-time generator/monitor pair:
//                gate-pair state codes, last-conducting-side codes, defaults.
//  Revision    : 1.0  initial release
// ============================================================================
package psm_pkg;

    // Default measurement width minus one (matches generator iSHIFT width)
    localparam int BITS_DATA_DEFAULT = 7;

    // Gate-pair states, taken directly from the registered {low, high} pair
    localparam logic [1:0] ST_DEAD  = 2'b00;
    localparam logic [1:0] ST_HI    = 2'b01;
    localparam logic [1:0] ST_LO    = 2'b10;
    localparam logic [1:0] ST_SHOOT = 2'b11;

    // Side that conducted most recently
    typedef enum logic [1:0] {
        SIDE_NONE = 2'd0,
        SIDE_HI   = 2'd1,
        SIDE_LO   = 2'd2
    } side_e;

endpackage : psm_pkg
`default_nettype wire

// File: rtl/psm_deadtime_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : psm_deadtime_monitor_if
//  Description : Gate-pair input, control and measurement/fault outputs of the
//                dead-time monitor. slave = monitor side, master = driver side.
//  Revision    : 1.0  initial release
// ============================================================================
interface psm_deadtime_monitor_if #(
    parameter int BITS_DATA = psm_pkg::BITS_DATA_DEFAULT
);
    logic [1:0]           iPSM;
    logic [BITS_DATA:0]   iMIN_DT;
    logic                 iCLR_FAULT;
    logic                 oPSM;
    logic [BITS_DATA:0]   oDT_RISE;
    logic [BITS_DATA:0]   oDT_FALL;
    logic [1:0]           oDT_VALID;
    logic                 oFAULT_SHOOT;
    logic                 oFAULT_DT;
    logic                 oFAULT;

    modport slave (
        input  iPSM, iMIN_DT, iCLR_FAULT,
        output oPSM, oDT_RISE, oDT_FALL, oDT_VALID, oFAULT_SHOOT, oFAULT_DT, oFAULT
    );

    modport master (
        output iPSM, iMIN_DT, iCLR_FAULT,
        input  oPSM, oDT_RISE, oDT_FALL, oDT_VALID, oFAULT_SHOOT, oFAULT_DT, oFAULT
    );
endinterface : psm_deadtime_monitor_if
`default_nettype wire

// File: rtl/psm_deadtime_monitor_gap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : psm_gap_counter
//  Description : Saturating up-counter with synchronous clear (priority over
//                enable) and asynchronous active-low reset.
//  Revision    : 1.0  initial release
// ============================================================================
module psm_gap_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             clr_i,
    input  wire logic             en_i,
    output logic [WIDTH-1:0]      cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : psm_gap_counter
`default_nettype wire

// File: rtl/psm_deadtime_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : psm_deadtime_monitor
//  Description : Receive-side checker for the complementary gate pair.
//                Recovers PSM, measures every dead-time gap and raises sticky
//                shoot-through / dead-time-too-short faults.
//  Revision    : 1.0  initial release
// ============================================================================
module psm_deadtime_monitor
    import psm_pkg::*;
#(
    parameter int BITS_DATA = BITS_DATA_DEFAULT
) (
    input  wire logic               CLK,
    input  wire logic               RST,
    psm_deadtime_monitor_if.slave   bus
);

    localparam int W = BITS_DATA + 1;

    logic [1:0]   r_q;        // registered gate pair, the only view used below
    logic [1:0]   st_q;       // state of the previous cycle, for entry detection
    side_e        side_q, side_d;
    logic [W-1:0] gap_cnt;
    logic         gap_en;
    logic         gap_clr;
    logic         enter_hi;
    logic         enter_lo;
    logic         measure;

    logic         psm_q, psm_d;
    logic [W-1:0] rise_q, rise_d;
    logic [W-1:0] fall_q, fall_d;
    logic [1:0]   valid_q, valid_d;
    logic         fshoot_q, fshoot_d;
    logic         fdt_q, fdt_d;
    logic         fault_q, fault_d;

    assign gap_en   = (r_q == ST_DEAD);
    assign gap_clr  = (r_q != ST_DEAD);
    assign enter_hi = (r_q == ST_HI) && (st_q != ST_HI);
    assign enter_lo = (r_q == ST_LO) && (st_q != ST_LO);

    // Counts consecutive dead cycles; any conducting or shoot cycle restarts it
    psm_gap_counter #(
        .WIDTH (W)
    ) u_gap_counter (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (gap_clr),
        .en_i   (gap_en),
        .cnt_o  (gap_cnt)
    );

    // Measurement, PSM recovery and sticky fault next-state
    always_comb begin
        side_d  = side_q;
        psm_d   = psm_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        valid_d = 2'b00;
        measure = 1'b0;
        if (enter_hi) begin
            psm_d  = 1'b1;
            side_d = SIDE_HI;
            if (side_q == SIDE_LO) begin
                rise_d     = gap_cnt;
                valid_d[0] = 1'b1;
                measure    = 1'b1;
            end
        end
        if (enter_lo) begin
            psm_d  = 1'b0;
            side_d = SIDE_LO;
            if (side_q == SIDE_HI) begin
                fall_d     = gap_cnt;
                valid_d[1] = 1'b1;
                measure    = 1'b1;
            end
        end
        // A new fault condition overrides a simultaneous clear
        fdt_d    = (measure && (gap_cnt < bus.iMIN_DT)) || (fdt_q && !bus.iCLR_FAULT);
        fshoot_d = (r_q == ST_SHOOT) || (fshoot_q && !bus.iCLR_FAULT);
        fault_d  = fdt_d || fshoot_d;
    end

    // Input stage plus all state and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q      <= ST_DEAD;
            st_q     <= ST_DEAD;
            side_q   <= SIDE_NONE;
            psm_q    <= 1'b0;
            rise_q   <= '0;
            fall_q   <= '0;
            valid_q  <= 2'b00;
            fshoot_q <= 1'b0;
            fdt_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            r_q      <= bus.iPSM;
            st_q     <= r_q;
            side_q   <= side_d;
            psm_q    <= psm_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            valid_q  <= valid_d;
            fshoot_q <= fshoot_d;
            fdt_q    <= fdt_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.oPSM         = psm_q;
    assign bus.oDT_RISE     = rise_q;
    assign bus.oDT_FALL     = fall_q;
    assign bus.oDT_VALID    = valid_q;
    assign bus.oFAULT_SHOOT = fshoot_q;
    assign bus.oFAULT_DT    = fdt_q;
    assign bus.oFAULT       = fault_q;

endmodule : psm_deadtime_monitor
`default_nettype wire

// File: tb/tb_psm_deadtime_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psm_deadtime_monitor
//  Description : Directed scenarios plus random gate-pair traffic, compared
//                cycle by cycle against a history-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_psm_deadtime_monitor;

    localparam int BD   = 7;
    localparam int SATV = (1 << (BD + 1)) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    psm_deadtime_monitor_if #(.BITS_DATA(BD)) bus ();

    psm_deadtime_monitor #(.BITS_DATA(BD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: history of the registered gate pair, one entry per cycle
    logic [1:0] m_r;
    logic [1:0] rhist[$];
    int m_psm, m_rise, m_fall, m_valid, m_fs, m_fdt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r = 2'b00;
        rhist.delete();
        m_psm = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_fs = 0; m_fdt = 0;
    endtask

    // Apply the rules to one clock edge: cur is the pair seen during the cycle
    task automatic model_edge(input logic [1:0] pin, input logic clr, input int min_dt);
        logic [1:0] cur, prev, side;
        int gap;
        bit meas;
        cur  = m_r;
        prev = (rhist.size() == 0) ? 2'b00 : rhist[rhist.size()-1];
        side = 2'b00;
        for (int i = rhist.size() - 1; i >= 0; i--) begin
            if (rhist[i] == 2'b01 || rhist[i] == 2'b10) begin
                side = rhist[i];
                break;
            end
        end
        gap = 0;
        for (int i = rhist.size() - 1; i >= 0; i--) begin
            if (rhist[i] != 2'b00) break;
            gap++;
        end
        if (gap > SATV) gap = SATV;
        meas    = 1'b0;
        m_valid = 0;
        if (cur == 2'b01 && prev != 2'b01) begin
            m_psm = 1;
            if (side == 2'b10) begin m_rise = gap; m_valid = 1; meas = 1'b1; end
        end
        if (cur == 2'b10 && prev != 2'b10) begin
            m_psm = 0;
            if (side == 2'b01) begin m_fall = gap; m_valid = 2; meas = 1'b1; end
        end
        m_fdt = ((meas && gap < min_dt) || (m_fdt != 0 && !clr)) ? 1 : 0;
        m_fs  = ((cur == 2'b11) || (m_fs != 0 && !clr)) ? 1 : 0;
        rhist.push_back(cur);
        m_r = pin;
    endtask

    task automatic compare_all();
        check_eq("oPSM",         32'(bus.oPSM),         32'(m_psm));
        check_eq("oDT_RISE",     32'(bus.oDT_RISE),     32'(m_rise));
        check_eq("oDT_FALL",     32'(bus.oDT_FALL),     32'(m_fall));
        check_eq("oDT_VALID",    32'(bus.oDT_VALID),    32'(m_valid));
        check_eq("oFAULT_SHOOT", 32'(bus.oFAULT_SHOOT), 32'(m_fs));
        check_eq("oFAULT_DT",    32'(bus.oFAULT_DT),    32'(m_fdt));
        check_eq("oFAULT",       32'(bus.oFAULT),       32'((m_fs | m_fdt) != 0));
    endtask

    task automatic step(input logic [1:0] psm, input logic clr);
        bus.iPSM       = psm;
        bus.iCLR_FAULT = clr;
        @(posedge CLK);
        model_edge(psm, clr, int'(bus.iMIN_DT));
        #1;
        compare_all();
    endtask

    task automatic run(input logic [1:0] psm, input int n);
        for (int i = 0; i < n; i++) step(psm, 1'b0);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge
    task automatic async_reset();
        #3 RST = 1'b0;
        #1;
        check_eq("rst_psm",   32'(bus.oPSM),      32'd0);
        check_eq("rst_rise",  32'(bus.oDT_RISE),  32'd0);
        check_eq("rst_fall",  32'(bus.oDT_FALL),  32'd0);
        check_eq("rst_valid", 32'(bus.oDT_VALID), 32'd0);
        check_eq("rst_fault", 32'({bus.oFAULT_SHOOT, bus.oFAULT_DT, bus.oFAULT}), 32'd0);
        model_reset();
        @(posedge CLK);
        #3 RST = 1'b1;
    endtask

    initial begin
        bus.iPSM       = 2'b00;
        bus.iMIN_DT    = '0;
        bus.iCLR_FAULT = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_eq("reset_state", 32'({bus.oPSM, bus.oDT_RISE, bus.oDT_FALL, bus.oDT_VALID,
                                     bus.oFAULT_SHOOT, bus.oFAULT_DT, bus.oFAULT}), 32'd0);
        #2 RST = 1'b1;

        // 1: basic rise/fall measurement
        run(2'b01, 10); run(2'b00, 5); run(2'b10, 10); run(2'b00, 7); run(2'b01, 3);
        check_eq("t1_fall", 32'(bus.oDT_FALL), 32'd5);
        check_eq("t1_rise", 32'(bus.oDT_RISE), 32'd7);
        check_eq("t1_psm",  32'(bus.oPSM),     32'd1);
        check_eq("t1_flt",  32'(bus.oFAULT),   32'd0);

        // 2: dead time too short, sticky, then cleared
        bus.iMIN_DT = 8'd6;
        run(2'b00, 5); run(2'b10, 4);
        check_eq("t2_fdt", 32'(bus.oFAULT_DT), 32'd1);
        run(2'b00, 8); run(2'b01, 3);
        check_eq("t2_hold", 32'(bus.oFAULT), 32'd1);
        step(2'b01, 1'b1);
        check_eq("t2_clr", 32'(bus.oFAULT), 32'd0);
        step(2'b01, 1'b0);

        // 3: shoot-through, zero gap, clear held during repeated shoot
        bus.iMIN_DT = 8'd3;
        step(2'b11, 1'b0); step(2'b10, 1'b0); run(2'b10, 3);
        check_eq("t3_fs",   32'(bus.oFAULT_SHOOT), 32'd1);
        check_eq("t3_fall", 32'(bus.oDT_FALL),     32'd0);
        check_eq("t3_fdt",  32'(bus.oFAULT_DT),    32'd1);
        step(2'b11, 1'b1); step(2'b11, 1'b1); step(2'b11, 1'b1);
        check_eq("t3_fs_hold", 32'(bus.oFAULT_SHOOT), 32'd1);
        run(2'b10, 3); step(2'b10, 1'b1);
        check_eq("t3_clr", 32'(bus.oFAULT), 32'd0);

        // 4: saturation of a long gap
        bus.iMIN_DT = 8'd0;
        run(2'b10, 3); run(2'b00, 300); run(2'b01, 3);
        check_eq("t4_sat", 32'(bus.oDT_RISE), 32'(SATV));

        // 5: first conduction unmeasured, swallowed pulse unmeasured
        async_reset();
        run(2'b10, 4);
        check_eq("t5_psm0", 32'(bus.oPSM), 32'd0);
        run(2'b00, 2); run(2'b10, 2); run(2'b00, 2); run(2'b01, 4);
        run(2'b00, 3); run(2'b01, 4);
        check_eq("t5_psm1", 32'(bus.oPSM), 32'd1);

        // 6: asynchronous reset mid-gap discards partial measurement
        run(2'b10, 4); run(2'b00, 2);
        async_reset();
        run(2'b10, 3); run(2'b00, 4); run(2'b01, 3);
        check_eq("t6_rise", 32'(bus.oDT_RISE), 32'd4);

        // Random traffic
        for (int seg = 0; seg < 400; seg++) begin
            logic [1:0] p;
            int len, sel;
            sel = int'($urandom_range(0, 19));
            if (sel < 7)       p = 2'b00;
            else if (sel < 12) p = 2'b01;
            else if (sel < 18) p = 2'b10;
            else               p = 2'b11;
            len = int'($urandom_range(1, 14));
            if ($urandom_range(0, 9) == 0) bus.iMIN_DT = 8'($urandom_range(0, 10));
            for (int k = 0; k < len; k++) step(p, ($urandom_range(0, 11) == 0));
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_psm_deadtime_monitor
`default_nettype wire
